// File: rtl/product_accumulator_if.sv
// Bus bundle for product_accumulator: product input stream, sum output stream,
// synchronous abort and the sticky overflow flag.
interface product_accumulator_if #(
  parameter int ACC_W = 24
);
  // Handshake contract (both streams): a transfer happens on a rising clk edge
  // where valid && ready; valid and its payload must not depend on ready.
  logic              clear;
  logic              in_valid;
  logic [15:0]       in_data;
  logic              in_ready;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic              out_ready;
  logic              overflow;

  modport master (
    output clear,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  overflow
  );

  modport slave (
    input  clear,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums ACC_COUNT unsigned 16-bit products into an ACC_W-bit result and holds it
// until the downstream handshake. Define PRODUCT_ACC_SAT_EN to saturate instead of wrap.
module product_accumulator #(
  parameter int ACC_COUNT = 4,
  parameter int ACC_W     = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  product_accumulator_if.slave           bus,
  output logic [1:0]                     dbg_state,
  output logic [$clog2(ACC_COUNT+1)-1:0] dbg_count
);

  localparam int CNT_W = $clog2(ACC_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              live_q;

  logic [ACC_W-1:0]  data_ext;
  logic [ACC_W:0]    sum;
  logic              in_ready_w;
  logic              out_valid_w;
  logic              beat;

  always_comb begin
    data_ext    = ACC_W'(bus.in_data);
    sum         = {1'b0, acc_q} + {1'b0, data_ext};
    // live_q keeps in_ready low until the first edge after reset is released.
    in_ready_w  = live_q && (state_q != HOLD);
    out_valid_w = (state_q == HOLD);
    beat        = bus.in_valid && in_ready_w;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (bus.clear) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beat) begin
            acc_d   = data_ext;
            count_d = CNT_ONE;
            ovf_d   = 1'b0;
            state_d = (ACC_COUNT == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            count_d = count_q + CNT_ONE;
            if (sum[ACC_W]) begin
              ovf_d = 1'b1;
            end
`ifdef PRODUCT_ACC_SAT_EN
            // Once saturated, stay pinned at the maximum for the rest of the group.
            if (sum[ACC_W] || ovf_q) begin
              acc_d = ACC_MAX;
            end else begin
              acc_d = sum[ACC_W-1:0];
            end
`else
            acc_d = sum[ACC_W-1:0];
`endif
            if (count_d == CNT_LAST) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      live_q  <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_valid_w ? acc_q : '0;
  assign bus.overflow  = ovf_q;
  assign dbg_state     = state_q;
  assign dbg_count     = count_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (4x24, 2x16, 1x24) checked
// against a running-sum reference model under directed and random traffic.
module tb_product_accumulator;

  localparam int C0 = 4, W0 = 24;
  localparam int C1 = 2, W1 = 16;
  localparam int C2 = 1, W2 = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(W0)) if0 ();
  product_accumulator_if #(.ACC_W(W1)) if1 ();
  product_accumulator_if #(.ACC_W(W2)) if2 ();

  logic [1:0] st0, st1, st2;
  logic [2:0] cnt0;
  logic [1:0] cnt1;
  logic [0:0] cnt2;

  product_accumulator #(.ACC_COUNT(C0), .ACC_W(W0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .dbg_state(st0), .dbg_count(cnt0));
  product_accumulator #(.ACC_COUNT(C1), .ACC_W(W1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .dbg_state(st1), .dbg_count(cnt1));
  product_accumulator #(.ACC_COUNT(C2), .ACC_W(W2)) dut2 (
    .clk(clk), .rst(rst), .bus(if2), .dbg_state(st2), .dbg_count(cnt2));

  // Drive side
  logic        d_valid[3];
  logic [15:0] d_data[3];
  logic        d_oready[3];
  logic        d_clear[3];

  assign if0.in_valid = d_valid[0];  assign if0.in_data = d_data[0];
  assign if0.out_ready = d_oready[0]; assign if0.clear = d_clear[0];
  assign if1.in_valid = d_valid[1];  assign if1.in_data = d_data[1];
  assign if1.out_ready = d_oready[1]; assign if1.clear = d_clear[1];
  assign if2.in_valid = d_valid[2];  assign if2.in_data = d_data[2];
  assign if2.out_ready = d_oready[2]; assign if2.clear = d_clear[2];

  // Observe side
  logic        o_ready[3];
  logic        o_valid[3];
  logic        o_ovf[3];
  logic [31:0] o_data[3];
  logic [31:0] o_cnt[3];

  always_comb begin
    o_ready[0] = if0.in_ready; o_valid[0] = if0.out_valid; o_ovf[0] = if0.overflow;
    o_ready[1] = if1.in_ready; o_valid[1] = if1.out_valid; o_ovf[1] = if1.overflow;
    o_ready[2] = if2.in_ready; o_valid[2] = if2.out_valid; o_ovf[2] = if2.overflow;
    o_data[0]  = 32'(if0.out_data);
    o_data[1]  = 32'(if1.out_data);
    o_data[2]  = 32'(if2.out_data);
    o_cnt[0]   = 32'(cnt0);
    o_cnt[1]   = 32'(cnt1);
    o_cnt[2]   = 32'(cnt2);
  end

  // Reference model: true sum of the current group, beats taken, result pending
  int     acc_count[3] = '{C0, C1, C2};
  int     acc_w[3]     = '{W0, W1, W2};
  bit     m_started;
  bit     m_hold[3];
  int     m_n[3];
  longint m_sum[3];
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic longint max_of(int i);
    return (64'd1 << acc_w[i]) - 1;
  endfunction

  function automatic logic [31:0] exp_data(int i);
`ifdef PRODUCT_ACC_SAT_EN
    return 32'((m_sum[i] > max_of(i)) ? max_of(i) : m_sum[i]);
`else
    return 32'(m_sum[i] & max_of(i));
`endif
  endfunction

  function automatic logic exp_ovf(int i);
    return m_sum[i] > max_of(i);
  endfunction

  task automatic model_reset();
    m_started = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_hold[i] = 1'b0; m_n[i] = 0; m_sum[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (d_clear[i]) begin
        if (i == 0 && m_hold[0] && exp_q.size() > 0) void'(exp_q.pop_front());
        m_hold[i] = 1'b0; m_n[i] = 0; m_sum[i] = 0;
      end else if (m_hold[i]) begin
        if (d_oready[i]) begin
          m_hold[i] = 1'b0; m_n[i] = 0; m_sum[i] = 0;
        end
      end else if (d_valid[i] && m_started) begin
        m_sum[i] += longint'(d_data[i]);
        m_n[i]++;
        if (m_n[i] == acc_count[i]) begin
          m_hold[i] = 1'b1;
          if (i == 0) exp_q.push_back(exp_data(0));
        end
      end
    end
    m_started = 1'b1;
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("in_ready%0d", i), o_ready[i], m_started && !m_hold[i]);
      check_eq($sformatf("out_valid%0d", i), o_valid[i], m_hold[i]);
      check_eq($sformatf("overflow%0d", i), o_ovf[i], exp_ovf(i));
      check_eq($sformatf("count%0d", i), o_cnt[i], 32'(m_n[i]));
      if (m_hold[i]) check_eq($sformatf("out_data%0d", i), o_data[i], exp_data(i));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s_in_ready%0d", tag, i), o_ready[i], 1'b0);
      check_eq($sformatf("%s_out_valid%0d", tag, i), o_valid[i], 1'b0);
      check_eq($sformatf("%s_out_data%0d", tag, i), o_data[i], 32'd0);
      check_eq($sformatf("%s_count%0d", tag, i), o_cnt[i], 32'd0);
      check_eq($sformatf("%s_overflow%0d", tag, i), o_ovf[i], 1'b0);
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      d_valid[i] = 1'b0; d_data[i] = '0; d_oready[i] = 1'b0; d_clear[i] = 1'b0;
    end
  endtask

  // One clock: score a pending handshake on instance 0, advance model, check.
  task automatic step();
    if (!rst && m_hold[0] && d_oready[0] && !d_clear[0] && exp_q.size() > 0)
      check_eq("sb_out_data0", o_data[0], exp_q.pop_front());
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic beat0(input logic [15:0] data, input logic ordy);
    d_valid[0] = 1'b1; d_data[0] = data; d_oready[0] = ordy;
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    check_all();
    step();
    check_eq("first_ready", o_ready[0], 1'b1);

    // 100+200+300+400 with out_ready high
    beat0(16'd100, 1'b1); beat0(16'd200, 1'b1); beat0(16'd300, 1'b1); beat0(16'd400, 1'b1);
    check_eq("sum4_valid", o_valid[0], 1'b1);
    check_eq("sum4_data", o_data[0], 32'd1000);
    check_eq("sum4_ovf", o_ovf[0], 1'b0);
    d_valid[0] = 1'b0;
    step();
    check_eq("sum4_done_valid", o_valid[0], 1'b0);
    check_eq("sum4_done_state", 32'(st0), 32'd0);

    // Same group with out_ready held low for five cycles
    beat0(16'd100, 1'b0); beat0(16'd200, 1'b0); beat0(16'd300, 1'b0); beat0(16'd400, 1'b0);
    d_data[0] = 16'd7;
    for (int k = 0; k < 5; k++) begin
      check_eq("hold_valid", o_valid[0], 1'b1);
      check_eq("hold_data", o_data[0], 32'd1000);
      check_eq("hold_ready", o_ready[0], 1'b0);
      if (k < 4) step();
    end
    d_valid[0] = 1'b0; d_oready[0] = 1'b1;
    step();
    check_eq("hold_release_valid", o_valid[0], 1'b0);
    d_oready[0] = 1'b0;

    // 16-bit overflow on instance 1
    d_valid[1] = 1'b1; d_data[1] = 16'hFFFF; step();
    d_data[1] = 16'h0002; step();
    d_valid[1] = 1'b0;
`ifdef PRODUCT_ACC_SAT_EN
    check_eq("ovf16_data", o_data[1], 32'h0000FFFF);
`else
    check_eq("ovf16_data", o_data[1], 32'h00000001);
`endif
    check_eq("ovf16_flag", o_ovf[1], 1'b1);
    d_oready[1] = 1'b1; step();
    check_eq("ovf16_cleared", o_ovf[1], 1'b0);
    d_oready[1] = 1'b0;

    // Single-beat group on instance 2
    d_valid[2] = 1'b1; d_data[2] = 16'hABCD; step();
    d_valid[2] = 1'b0;
    check_eq("single_valid", o_valid[2], 1'b1);
    check_eq("single_data", o_data[2], 32'h0000ABCD);
    d_oready[2] = 1'b1; step();
    d_oready[2] = 1'b0;

    // Reset after two beats, then a fresh group of ones
    beat0(16'd5, 1'b0); beat0(16'd6, 1'b0);
    d_valid[0] = 1'b0;
    pulse_reset();
    step();
    check_eq("post_rst_ready", o_ready[0], 1'b1);
    for (int k = 0; k < 4; k++) beat0(16'd1, 1'b0);
    d_valid[0] = 1'b0;
    check_eq("post_rst_data", o_data[0], 32'd4);
    d_oready[0] = 1'b1; step();

    // Clear coinciding with the fourth beat
    d_oready[0] = 1'b1;
    beat0(16'd10, 1'b1); beat0(16'd20, 1'b1); beat0(16'd30, 1'b1);
    d_clear[0] = 1'b1;
    beat0(16'd40, 1'b1);
    d_clear[0] = 1'b0; d_valid[0] = 1'b0;
    check_eq("clear_valid", o_valid[0], 1'b0);
    check_eq("clear_count", o_cnt[0], 32'd0);
    check_eq("clear_state", 32'(st0), 32'd0);

    // Random traffic on all three instances
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) begin
        d_valid[i]  = ($urandom_range(0, 99) < 70);
        d_data[i]   = 16'($urandom_range(0, 65535));
        d_oready[i] = ($urandom_range(0, 99) < 60);
        d_clear[i]  = ($urandom_range(0, 99) < 4);
      end
      step();
      if ($urandom_range(0, 99) < 2) pulse_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
